// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encoding
// and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/one_bit_full_adder.sv
// Single full-adder slice; the only arithmetic in the serial adder datapath.
module one_bit_full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic w_prop;

    assign w_prop = A ^ B;
    assign Sum    = w_prop ^ Cin;
    assign Cout   = (A & B) | (Cin & w_prop);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice per clock, LSB first, producing
// {Cout, Sum_out} = A_in + B_in + Cin after WIDTH RUN cycles.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum_out,
    output logic             Cout
);

    localparam int              IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum_out;
    logic               r_cout;

    logic               w_sum;
    logic               w_cout;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_shifted;

    one_bit_full_adder u_fa (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Cin  (r_carry),
        .Sum  (w_sum),
        .Cout (w_cout)
    );

    // start is honoured in IDLE and in the one-cycle DONE state, never in RUN.
    assign w_accept      = start && (r_state != RUN);
    assign w_last        = (r_idx == LAST_IDX);
    assign w_sum_shifted = {w_sum, r_sum[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_last) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Operand shift registers, carry and bit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= w_sum_shifted;
            r_carry <= w_cout;
            r_idx   <= r_idx + IDX_W'(1);
        end else if (w_accept) begin
            r_a     <= A_in;
            r_b     <= B_in;
            r_sum   <= '0;
            r_carry <= Cin;
            r_idx   <= '0;
        end
    end

    // Visible result changes only on the final slice, so an aborted run leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum_out <= '0;
            r_cout    <= 1'b0;
        end else if ((r_state == RUN) && w_last) begin
            r_sum_out <= w_sum_shifted;
            r_cout    <= w_cout;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign Sum_out = r_sum_out;
    assign Cout    = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: stimulus pushes expected results,
// a monitor pops and compares them whenever done is seen.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         cout;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;
    int n_done = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W:0]   res;
        int           due;
    } exp_t;

    exp_t sb[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .A_in    (a_in),
        .B_in    (b_in),
        .Cin     (cin),
        .busy    (busy),
        .done    (done),
        .Sum_out (sum_out),
        .Cout    (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Expected result from plain arithmetic; done is due WIDTH edges after the accepting edge.
    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.c   = c;
        e.res = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
        e.due = cyc + 1 + W;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        push_exp(a, b, c);
        tick(1);
        check("busy_after_accept", busy, 1'b1);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        cin   = 1'($urandom);
        tick(W);
        check("busy_in_done", busy, 1'b0);
    endtask

    // Monitor: compare on every done, flag spurious or missing pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    n_done++;
                    check("sum_cout", {cout, sum_out}, e.res);
                    check("done_cycle", cyc, e.due);
                    $display("op %0d: 0x%02h + 0x%02h + %0d -> cout=%0d sum=0x%02h (exp %0d/0x%02h) at cycle %0d",
                             n_done, e.a, e.b, e.c, cout, sum_out, e.res[W], e.res[W-1:0], cyc);
                end
            end else if (sb.size() > 0 && cyc >= sb[0].due) begin
                check("done_missing", done, 1'b1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] last_res;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        tick(3);
        start = 1'b1;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        tick(1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_sum", sum_out, 8'h00);
        check("reset_cout", cout, 1'b0);
        start = 1'b0;
        rst   = 1'b0;
        tick(2);

        issue(8'h3C, 8'h42, 1'b0);
        tick(1);
        issue(8'hFF, 8'h01, 1'b0);
        tick(2);
        issue(8'hA5, 8'h5A, 1'b1);

        // Hold after completion.
        tick(5);
        check("hold_sum", sum_out, 8'h00);
        check("hold_cout", cout, 1'b1);
        check("hold_done", done, 1'b0);

        // Re-pulse during RUN must be ignored.
        start = 1'b1;
        a_in  = 8'h12;
        b_in  = 8'h34;
        cin   = 1'b0;
        push_exp(8'h12, 8'h34, 1'b0);
        tick(1);
        start = 1'b0;
        tick(2);
        start = 1'b1;
        a_in  = 8'hEE;
        b_in  = 8'hEE;
        cin   = 1'b1;
        tick(1);
        start = 1'b0;
        tick(W - 3);
        tick(3);
        check("repulse_busy", busy, 1'b0);
        check("repulse_sum", sum_out, 8'h46);

        // start held high across RUN and DONE: second op follows with no idle gap.
        start = 1'b1;
        a_in  = 8'h80;
        b_in  = 8'h81;
        cin   = 1'b1;
        push_exp(8'h80, 8'h81, 1'b1);
        tick(1);
        a_in  = 8'h07;
        b_in  = 8'h09;
        cin   = 1'b0;
        tick(W);
        check("b2b_done_state_busy", busy, 1'b0);
        check("b2b_done_pulse", done, 1'b1);
        push_exp(8'h07, 8'h09, 1'b0);
        tick(1);
        check("b2b_no_gap_busy", busy, 1'b1);
        start = 1'b0;
        tick(W);
        check("b2b_second_sum", sum_out, 8'h10);

        // Reset after three RUN cycles aborts without a done pulse.
        start = 1'b1;
        a_in  = 8'h77;
        b_in  = 8'h11;
        cin   = 1'b0;
        tick(1);
        start = 1'b0;
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sum", sum_out, 8'h00);
        check("abort_cout", cout, 1'b0);
        tick(W + 4);
        check("abort_sum_later", sum_out, 8'h00);
        issue(8'h01, 8'h01, 1'b0);
        check("after_abort_sum", sum_out, 8'h02);

        // Random sweep with random idle gaps, including back-to-back starts.
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            tick($urandom_range(0, 2));
        end
        last_res = {cout, sum_out};
        tick(W + 3);
        check("scoreboard_empty", sb.size(), 0);
        check("final_hold", {cout, sum_out}, last_res);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
